// File: rtl/lat_mon_pkg.sv
// rtl/lat_mon_pkg.sv - shared error codes and channel state type for the latency monitor
package lat_mon_pkg;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_OVERLAP  = 3'd2;
    localparam logic [2:0] ERR_SPURIOUS = 3'd3;
    localparam logic [2:0] ERR_REISSUE  = 3'd4;
    localparam logic [2:0] ERR_LONG     = 3'd5;
    localparam logic [2:0] ERR_SHORT    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ch_state_e;

endpackage

// File: rtl/lat_mon_ch.sv
// rtl/lat_mon_ch.sv - per-channel handshake FSM with latency and hold counters
module lat_mon_ch
    import lat_mon_pkg::*;
#(
    parameter int MAX_LAT  = 1000,
    parameter int OUT_HOLD = 1,
    parameter int LAT_W    = $clog2(MAX_LAT + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iv_i,
    input  logic             ov_i,
    output logic             done_o,
    output logic [LAT_W-1:0] lat_o,
    output logic             err_o,
    output logic [2:0]       code_o
);

    localparam int HOLD_W = $clog2(OUT_HOLD + 1);
    localparam logic [LAT_W-1:0]  LAT_LIMIT = LAT_W'(MAX_LAT);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(OUT_HOLD);

    ch_state_e         state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            hold_q  <= hold_d;
        end
    end

    // Events are combinational here; the top registers them so every output is one edge behind.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        hold_d  = hold_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        code_o  = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (iv_i) begin
                    if (ov_i) begin
                        err_o  = 1'b1;
                        code_o = ERR_OVERLAP;
                    end
                    state_d = ST_WAIT;
                    lat_d   = '0;
                end else if (ov_i) begin
                    err_o  = 1'b1;
                    code_o = ERR_SPURIOUS;
                end
            end
            ST_WAIT: begin
                if (iv_i && ov_i) begin
                    err_o   = 1'b1;
                    code_o  = ERR_OVERLAP;
                    state_d = ST_IDLE;
                end else if (ov_i) begin
                    state_d = ST_HOLD;
                    lat_d   = lat_q + LAT_W'(1);
                    hold_d  = HOLD_W'(1);
                end else if (iv_i) begin
                    err_o  = 1'b1;
                    code_o = ERR_REISSUE;
                    lat_d  = '0;
                end else if (lat_q == LAT_LIMIT) begin
                    err_o   = 1'b1;
                    code_o  = ERR_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_HOLD: begin
                if (iv_i && ov_i) begin
                    err_o   = 1'b1;
                    code_o  = ERR_OVERLAP;
                    state_d = ST_IDLE;
                end else if (ov_i) begin
                    if (hold_q == HOLD_LIMIT) begin
                        err_o   = 1'b1;
                        code_o  = ERR_LONG;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else if (hold_q != HOLD_LIMIT) begin
                    err_o   = 1'b1;
                    code_o  = ERR_SHORT;
                    state_d = ST_IDLE;
                end else begin
                    done_o = 1'b1;
                    if (iv_i) begin
                        state_d = ST_WAIT;
                        lat_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lat_o = lat_q;

endmodule

// File: rtl/lat_proto_monitor.sv
// rtl/lat_proto_monitor.sv - multi-channel handshake protocol checker and latency statistics
module lat_proto_monitor
    import lat_mon_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int MAX_LAT  = 1000,
    parameter int OUT_HOLD = 1,
    parameter int ACC_W    = 32,
    parameter int LAT_W    = $clog2(MAX_LAT + 2),
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       mon_in_valid,
    input  logic [NUM_CH-1:0]       mon_out_valid,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       done_valid,
    output logic [NUM_CH*LAT_W-1:0] done_lat,
    output logic [NUM_CH-1:0]       err_valid,
    output logic [NUM_CH*3-1:0]     err_code,
    output logic [ACC_W-1:0]        total_lat,
    output logic [ACC_W-1:0]        txn_cnt,
    output logic [LAT_W-1:0]        max_lat,
    output logic                    sticky_err,
    output logic [2:0]              first_err_code,
    output logic [CH_W-1:0]         first_err_ch
);

    localparam int SUM_W = LAT_W + $clog2(NUM_CH + 1);
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [ACC_W-1:0] ACC_ONES = '1;

    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_err;
    logic [LAT_W-1:0]  ch_lat  [NUM_CH];
    logic [2:0]        ch_code [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        lat_mon_ch #(
            .MAX_LAT  (MAX_LAT),
            .OUT_HOLD (OUT_HOLD),
            .LAT_W    (LAT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .iv_i   (mon_in_valid[g]),
            .ov_i   (mon_out_valid[g]),
            .done_o (ch_done[g]),
            .lat_o  (ch_lat[g]),
            .err_o  (ch_err[g]),
            .code_o (ch_code[g])
        );
    end

    logic [NUM_CH-1:0]       done_valid_q;
    logic [NUM_CH*LAT_W-1:0] done_lat_q, done_lat_d;
    logic [NUM_CH-1:0]       err_valid_q;
    logic [NUM_CH*3-1:0]     err_code_q, err_code_d;
    logic [ACC_W-1:0]        total_q, total_d;
    logic [ACC_W-1:0]        txn_q, txn_d;
    logic [LAT_W-1:0]        max_q, max_d;
    logic                    sticky_q;
    logic [2:0]              first_code_q, sel_code;
    logic [CH_W-1:0]         first_ch_q, sel_ch;
    logic                    any_err;
    logic [SUM_W-1:0]        lat_sum, cnt_sum;
    logic [EXT_W-1:0]        total_ext, txn_ext;

    always_comb begin
        done_lat_d = '0;
        err_code_d = '0;
        lat_sum    = '0;
        cnt_sum    = '0;
        max_d      = max_q;
        any_err    = 1'b0;
        sel_ch     = '0;
        sel_code   = ERR_NONE;
        for (int i = 0; i < NUM_CH; i++) begin
            err_code_d[i*3 +: 3] = ch_code[i];
            if (ch_done[i]) begin
                done_lat_d[i*LAT_W +: LAT_W] = ch_lat[i];
                lat_sum = lat_sum + SUM_W'(ch_lat[i]);
                cnt_sum = cnt_sum + SUM_W'(1);
                if (ch_lat[i] > max_d) begin
                    max_d = ch_lat[i];
                end
            end
        end
        // Scan downward so the lowest erring channel is the one left selected.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_err[i]) begin
                any_err  = 1'b1;
                sel_ch   = CH_W'(i);
                sel_code = ch_code[i];
            end
        end
        total_ext = EXT_W'(total_q) + EXT_W'(lat_sum);
        txn_ext   = EXT_W'(txn_q) + EXT_W'(cnt_sum);
        total_d   = (total_ext > EXT_W'(ACC_ONES)) ? ACC_ONES : total_ext[ACC_W-1:0];
        txn_d     = (txn_ext > EXT_W'(ACC_ONES)) ? ACC_ONES : txn_ext[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid_q <= '0;
            done_lat_q   <= '0;
            err_valid_q  <= '0;
            err_code_q   <= '0;
            total_q      <= '0;
            txn_q        <= '0;
            max_q        <= '0;
            sticky_q     <= 1'b0;
            first_code_q <= ERR_NONE;
            first_ch_q   <= '0;
        end else begin
            done_valid_q <= ch_done;
            done_lat_q   <= done_lat_d;
            err_valid_q  <= ch_err;
            err_code_q   <= err_code_d;
            if (clear) begin
                total_q      <= '0;
                txn_q        <= '0;
                max_q        <= '0;
                sticky_q     <= 1'b0;
                first_code_q <= ERR_NONE;
                first_ch_q   <= '0;
            end else begin
                total_q <= total_d;
                txn_q   <= txn_d;
                max_q   <= max_d;
                if (any_err && !sticky_q) begin
                    sticky_q     <= 1'b1;
                    first_code_q <= sel_code;
                    first_ch_q   <= sel_ch;
                end
            end
        end
    end

    assign done_valid     = done_valid_q;
    assign done_lat       = done_lat_q;
    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign total_lat      = total_q;
    assign txn_cnt        = txn_q;
    assign max_lat        = max_q;
    assign sticky_err     = sticky_q;
    assign first_err_code = first_code_q;
    assign first_err_ch   = first_ch_q;

endmodule

// File: tb/tb_lat_proto_monitor.sv
// tb/tb_lat_proto_monitor.sv - directed self-checking bench for lat_proto_monitor
module tb_lat_proto_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [1:0] iv, ov, ivh, ovh;

    logic [1:0]  dv, ev, dvh, evh;
    logic [7:0]  dl, dlh;
    logic [5:0]  ec, ech;
    logic [31:0] tot, txn, toth, txnh;
    logic [3:0]  mx, mxh;
    logic        stk, stkh;
    logic [2:0]  fcode, fcodeh;
    logic [0:0]  fch, fchh;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lat_proto_monitor #(.NUM_CH(2), .MAX_LAT(8), .OUT_HOLD(1), .ACC_W(32)) u_dut (
        .clk(clk), .rst(rst), .mon_in_valid(iv), .mon_out_valid(ov), .clear(clear),
        .done_valid(dv), .done_lat(dl), .err_valid(ev), .err_code(ec),
        .total_lat(tot), .txn_cnt(txn), .max_lat(mx), .sticky_err(stk),
        .first_err_code(fcode), .first_err_ch(fch)
    );

    lat_proto_monitor #(.NUM_CH(2), .MAX_LAT(8), .OUT_HOLD(2), .ACC_W(32)) u_dut_h2 (
        .clk(clk), .rst(rst), .mon_in_valid(ivh), .mon_out_valid(ovh), .clear(clear),
        .done_valid(dvh), .done_lat(dlh), .err_valid(evh), .err_code(ech),
        .total_lat(toth), .txn_cnt(txnh), .max_lat(mxh), .sticky_err(stkh),
        .first_err_code(fcodeh), .first_err_ch(fchh)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; iv = '0; ov = '0; ivh = '0; ovh = '0;
        tick(2);
        check("rst_done_valid", dv, 0);
        check("rst_err_valid", ev, 0);
        check("rst_done_lat", dl, 0);
        check("rst_err_code", ec, 0);
        check("rst_total", tot, 0);
        check("rst_txn", txn, 0);
        check("rst_max", mx, 0);
        check("rst_sticky", stk, 0);
        check("rst_first_code", fcode, 0);
        check("rst_first_ch", fch, 0);
        rst = 1'b0;
        tick(1);

        // nominal: iv edge 0, ov edge 5
        iv = 2'b01; tick(1);
        iv = 2'b00; tick(4);
        ov = 2'b01; tick(1);
        check("nom_not_yet", dv, 0);
        ov = 2'b00; tick(1);
        check("nom_done_valid", dv, 2'b01);
        check("nom_done_lat", dl[3:0], 5);
        check("nom_total", tot, 5);
        check("nom_txn", txn, 1);
        check("nom_max", mx, 5);
        tick(1);
        check("nom_pulse_end", dv, 0);

        // timeout on ch1
        iv = 2'b10; tick(1);
        iv = 2'b00; tick(8);
        check("to_early", ev, 0);
        tick(1);
        check("to_err_valid", ev, 2'b10);
        check("to_code", ec[5:3], 1);
        check("to_sticky", stk, 1);
        check("to_first_ch", fch, 1);
        check("to_first_code", fcode, 1);
        tick(1);
        check("to_pulse_end", ev, 0);
        ov = 2'b10; tick(1);
        check("spur_valid", ev, 2'b10);
        check("spur_code", ec[5:3], 3);
        check("spur_first_kept", fcode, 1);
        ov = 2'b00;

        clear = 1'b1; tick(1);
        clear = 1'b0;
        check("clr_sticky", stk, 0);
        check("clr_total", tot, 0);
        check("clr_txn", txn, 0);
        check("clr_max", mx, 0);

        // overlap in WAIT
        iv = 2'b01; tick(1);
        iv = 2'b00; tick(2);
        iv = 2'b01; ov = 2'b01; tick(1);
        check("ovl_valid", ev, 2'b01);
        check("ovl_code", ec[2:0], 2);
        check("ovl_first_code", fcode, 2);
        check("ovl_first_ch", fch, 0);
        iv = 2'b00; ov = 2'b00; tick(1);
        check("ovl_no_done", dv, 0);

        // reissue then completion with latency 4
        iv = 2'b01; tick(1);
        iv = 2'b00; tick(1);
        iv = 2'b01; tick(1);
        check("reis_valid", ev, 2'b01);
        check("reis_code", ec[2:0], 4);
        iv = 2'b00; tick(3);
        ov = 2'b01; tick(1);
        ov = 2'b00; tick(1);
        check("reis_done", dv, 2'b01);
        check("reis_lat", dl[3:0], 4);
        check("reis_total", tot, 4);
        check("reis_txn", txn, 1);
        check("reis_max", mx, 4);
        check("reis_first_kept", fcode, 2);

        // simultaneous completion: ch1 lat 7, ch0 lat 3
        iv = 2'b10; tick(1);
        iv = 2'b00; tick(3);
        iv = 2'b01; tick(1);
        iv = 2'b00; tick(2);
        ov = 2'b11; tick(1);
        ov = 2'b00; tick(1);
        check("sim_done", dv, 2'b11);
        check("sim_lat0", dl[3:0], 3);
        check("sim_lat1", dl[7:4], 7);
        check("sim_total", tot, 14);
        check("sim_txn", txn, 3);
        check("sim_max", mx, 7);

        // same again with clear on the completing edge
        iv = 2'b10; tick(1);
        iv = 2'b00; tick(3);
        iv = 2'b01; tick(1);
        iv = 2'b00; tick(2);
        ov = 2'b11; tick(1);
        ov = 2'b00; clear = 1'b1; tick(1);
        clear = 1'b0;
        check("simclr_total", tot, 0);
        check("simclr_txn", txn, 0);
        check("simclr_max", mx, 0);
        check("simclr_sticky", stk, 0);

        // OUT_HOLD=2: short pulse
        ivh = 2'b01; tick(1);
        ivh = 2'b00; tick(1);
        ovh = 2'b01; tick(1);
        ovh = 2'b00; tick(1);
        check("short_valid", evh, 2'b01);
        check("short_code", ech[2:0], 6);

        // long pulse
        ivh = 2'b01; tick(1);
        ivh = 2'b00; tick(1);
        ovh = 2'b01; tick(2);
        check("long_not_yet", evh, 0);
        tick(1);
        check("long_valid", evh, 2'b01);
        check("long_code", ech[2:0], 5);
        ovh = 2'b00; tick(1);

        // exact pulse width completes
        ivh = 2'b01; tick(1);
        ivh = 2'b00; tick(1);
        ovh = 2'b01; tick(2);
        check("exact_not_yet", dvh, 0);
        ovh = 2'b00; tick(1);
        check("exact_done", dvh, 2'b01);
        check("exact_lat", dlh[3:0], 2);
        check("exact_txn", txnh, 1);
        check("exact_total", toth, 2);
        check("exact_no_err", evh, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
